// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared definitions for the 7-segment scan path.
//   SEG_CODE_BLANK : digit code that makes the downstream decoder blank a digit
//   AN_ALL_OFF     : active-low anode vector with every digit dark
//   scan_state_t   : slot phase (BLANK anti-ghosting gap, then ON)
//   MAX_DIGITS     : widest display the scanner can drive
//   lead_zero_mask : helper used when SEG_SCAN_LZB_EN is defined
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int unsigned MAX_DIGITS     = 8;
  localparam logic [7:0]  SEG_CODE_BLANK = 8'hFF;
  localparam logic [7:0]  AN_ALL_OFF     = 8'hFF;

  typedef enum logic [0:0] {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_t;

  // Bit i set when nibble i and every higher nibble below num_digits are zero.
  // Digit 0 is never flagged so a zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int unsigned             num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < int'(num_digits)) begin
        zero_above = zero_above & (value[4*i +: 4] == 4'h0);
        mask[i]    = zero_above;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// ---------------------------------------------------------------------------
// seg_slot_timer -- per-digit slot timing for seg_scan.
// Counts SCAN_DIV cycles per slot; the first BLANK_CYC cycles are the BLANK
// phase, the rest are ON.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   slot_end_o  : counter is on the last cycle of the slot (wraps at next edge)
//   on_phase_o  : phase the slot will be in after the next edge, so the parent
//                 can register its outputs on the same edge as the transition
// ---------------------------------------------------------------------------
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end_o,
  output logic on_phase_o
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_t   state_q, state_d;
  logic          slot_end_s;

  assign slot_end_s = (cnt_q == CNT_LAST);

  // State and slot counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= SCAN_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next counter value and next phase.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (slot_end_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
    case (state_q)
      // With no blank gap the post-reset BLANK cycle falls straight into ON.
      SCAN_BLANK: begin
        if ((BLANK_CYC == 0) || (cnt_q == BLANK_LAST)) begin
          state_d = SCAN_ON;
        end else begin
          state_d = SCAN_BLANK;
        end
      end
      SCAN_ON: begin
        if (slot_end_s) begin
          state_d = (BLANK_CYC == 0) ? SCAN_ON : SCAN_BLANK;
        end else begin
          state_d = SCAN_ON;
        end
      end
      default: state_d = SCAN_BLANK;
    endcase
  end

  // Timer outputs to the scanner core.
  always_comb begin
    slot_end_o = slot_end_s;
    on_phase_o = (state_d == SCAN_ON);
  end

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan -- time-multiplexed scanner for a common-anode 7-segment display.
// A 32-bit value is accepted over valid/ready into a one-deep pending register
// and swapped into the displayed register only when the digit index wraps to
// 0, so a frame never mixes two values.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : upstream offers in_data
//   in_ready     : pending register empty (value can be accepted)
//   in_data      : eight nibbles, nibble 0 = rightmost digit
//   digit_en     : live per-digit enable mask (0 = dark)
//   code         : digit code to the decoder (0-15, or 8'hFF for blank)
//   an           : active-low anode enables
//   frame_start  : one-cycle pulse on the edge the digit index wraps to 0
// Build option: define SEG_SCAN_LZB_EN for leading-zero blanking.
// ---------------------------------------------------------------------------
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [7:0]  digit_en,
  output logic [7:0]  code,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam logic [2:0] DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic        slot_end_s, on_phase_s;
  logic        wrap_s, commit_s, accept_s, show_s;
  logic [2:0]  digit_q, digit_d;
  logic [31:0] active_q, active_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  an_q, an_d;
  logic        frame_start_q;
  logic [3:0]  nib_s;
  logic [7:0]  lz_s;

  seg_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_end_o (slot_end_s),
    .on_phase_o (on_phase_s)
  );

  // Scanner core registers: digit index, handshake buffer, display value, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q       <= 3'd0;
      active_q      <= 32'h0000_0000;
      pend_q        <= 32'h0000_0000;
      pend_full_q   <= 1'b0;
      code_q        <= SEG_CODE_BLANK;
      an_q          <= AN_ALL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      digit_q       <= digit_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      code_q        <= code_d;
      an_q          <= an_d;
      frame_start_q <= wrap_s;
    end
  end

  // Digit advance, frame commit and handshake acceptance.
  always_comb begin
    wrap_s   = slot_end_s && (digit_q == DIGIT_LAST);
    // Accept needs an empty buffer and commit a full one, so they never coincide.
    commit_s = wrap_s && pend_full_q;
    accept_s = in_valid && !pend_full_q;
    if (!slot_end_s) begin
      digit_d = digit_q;
    end else if (wrap_s) begin
      digit_d = 3'd0;
    end else begin
      digit_d = digit_q + 3'd1;
    end
    if (commit_s) begin
      active_d = pend_q;
    end else begin
      active_d = active_q;
    end
    if (accept_s) begin
      pend_d      = in_data;
      pend_full_d = 1'b1;
    end else if (commit_s) begin
      pend_d      = pend_q;
      pend_full_d = 1'b0;
    end else begin
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
    end
  end

  // Next output values, built from next-edge state so they move with the slot.
  always_comb begin
    nib_s = active_d[{digit_d, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
    lz_s  = lead_zero_mask(active_d, NUM_DIGITS);
`else
    lz_s  = 8'h00;
`endif
    show_s = on_phase_s && digit_en[digit_d] && !lz_s[digit_d];
    if (show_s) begin
      code_d = {4'h0, nib_s};
      an_d   = ~(8'h01 << digit_d);
    end else begin
      code_d = SEG_CODE_BLANK;
      an_d   = AN_ALL_OFF;
    end
  end

  assign in_ready    = ~pend_full_q;
  assign code        = code_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Time-multiplexed scanner for the board's 8-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder and feeds it one 8-bit digit code per slot. Valid codes are 0-15; code 8'hFF makes the decoder blank the digit. The scanner also drives the active-low anode enables. It accepts a 32-bit display value through a valid/ready handshake and swaps it in only at frame boundaries, so the display never shows a half-updated value (no tearing).

Parameters:
NUM_DIGITS, 8, number of digits scanned (1-8); digit i shows data[4i+3:4i].
SCAN_DIV, 100000, clk cycles per digit slot; must be >= BLANK_CYC+2.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents a new display value
in_ready  out  1  scanner can accept a value (= ~pend_full)
in_data  in  32  eight hex nibbles; nibble 0 is the rightmost digit
digit_en  in  8  per-digit enable mask, sampled live; bit i=0 -> digit i dark
code  out  8  digit code to the decoder: 0-15, or 8'hFF for blank
an  out  8  anode enables, active-low; bits >= NUM_DIGITS are held 1
frame_start  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset: all registers clear asynchronously.
  - Cleared values: cnt=0, digit=0, state=BLANK, active=0, pend=0, pend_full=0.
  - Output reset values: code=8'hFF, an=8'hFF, frame_start=0, in_ready=1.
- Slot counter: cnt counts 0..SCAN_DIV-1, then wraps to 0. Width is $clog2(SCAN_DIV).
- Digit index: increments modulo NUM_DIGITS each time cnt wraps.
- State machine, two states:
  - BLANK: active for cnt < BLANK_CYC.
  - ON: active for the remainder of the slot.
  - BLANK->ON when cnt==BLANK_CYC-1; ON->BLANK when cnt==SCAN_DIV-1.
  - If BLANK_CYC=0, BLANK is skipped and each slot is ON from cnt 0.
- Outputs are registered and update on the same clk edge as the state/counter transition they belong to.
  - BLANK: an=8'hFF, code=8'hFF.
  - ON with digit_en[digit]=1: an has only bit [digit] low; code={4'h0, active nibble[digit]}.
  - ON with digit_en[digit]=0: an=8'hFF, code=8'hFF.
- Handshake: a transfer occurs when in_valid && in_ready. The accepted value goes to pend and pend_full is set.
- Commit: on the edge where digit wraps NUM_DIGITS-1->0, if pend_full then active<=pend and pend_full is cleared.
  - frame_start pulses on that same edge.
- Simultaneous accept and commit: impossible, because accept requires pend_full=0 and commit requires pend_full=1.
- Accept on the wrap edge with pend empty: the value stays in pend and commits at the next wrap, one frame later.
- Back-to-back values: in_ready stays low until the next commit, which gives natural backpressure. There is at most one value in flight.
- NUM_DIGITS=1: digit stays 0, and every slot end is a wrap and a frame_start.
- Reset mid-frame: pending data is discarded, the display blanks immediately, and scanning restarts at digit 0 in BLANK.

Optional Feature:
SEG_SCAN_LZB_EN: leading-zero blanking.
- Defined: during ON, digit i outputs code=8'hFF and an all-1s if nibble i and every higher enabled nibble (up to NUM_DIGITS-1) of active are zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - A combinational leading-zero mask is computed from active only; it is stable for the whole frame.
- Undefined: every enabled digit is shown, zeros included. No mask logic is generated.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_CODE_BLANK = 8'hFF;
  - AN_ALL_OFF = 8'hFF;
  - typedef scan_state_t {SCAN_BLANK, SCAN_ON};
  - MAX_DIGITS = 8.
- One natural sub-module: seg_slot_timer. It holds cnt and state and emits slot_end and on_phase.
- The scanner core (digit index, handshake, pend/active registers, output muxing) stays in seg_scan.
- The decoder is instantiated by the parent top, not inside seg_scan.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=8 unless stated.
- Scan pattern: after reset, send in_data=32'h89ABCDEF with digit_en=8'hFF.
  - Until the first wrap, code=0 on all slots (active=0).
  - From the next frame, slot 0 has an=8'hFE for cycles 2..7 with code=8'h0F; slot 7 has an=8'h7F with code=8'h08.
  - an=8'hFF during cnt 0..1 of every slot.
- No tearing: send 32'h11111111, then 32'h22222222 mid-frame.
  - The second value sees in_ready=0 until frame_start.
  - Frame N shows all 1s; frame N+1 shows all 2s; no frame mixes the two.
- Mask: digit_en=8'h0F -> digits 4-7 have an=8'hFF and code=8'hFF in ON; digits 0-3 are driven normally.
- Reset mid-slot: assert rst_n=0 at digit 3, cnt 5, with pend_full=1.
  - Next sample: an=8'hFF, code=8'hFF, in_ready=1.
  - After release, scanning resumes at digit 0 with active=0.
- NUM_DIGITS=1: frame_start pulses every 8 cycles; an[7:1] stays 1.
- SEG_SCAN_LZB_EN defined:
  - active=32'h000000A0 -> digits 0-1 show 0x00/0x0A; digits 2-7 are dark.
  - active=0 -> only digit 0 shows code 0x00.
